unary_reduction_sequencer: RTL and testbench

Multi-cycle sequencer that evaluates a unary reduction (AND/OR/XOR and their inversions) over a wide operand by streaming it, N bits per cycle, through a single N-bit reduction datapath. It accumulates partial results across K chunks and returns one result bit under a valid/ready handshake. The block sits between a requesting pipeline stage and the shared combinational reduction logic, so wide reductions reuse one narrow unit instead of a W-bit tree.

---
 rtl/unary_reduction_pkg.sv | 39 +++
 rtl/unary_reduction_sequencer_chunk_reduce.sv | 52 +++++
 rtl/unary_reduction_sequencer.sv | 111 +++++++++++
 tb/tb_unary_reduction_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/unary_reduction_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unary_reduction_pkg
//  Description : Shared types and helpers for the unary reduction sequencer.
//  Revision    : 1.0
// ============================================================================
package unary_reduction_pkg;

    typedef enum logic [1:0] {
        RED_AND,
        RED_OR,
        RED_XOR,
        RED_ILLEGAL
    } red_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    // Neutral element the accumulator starts from; illegal ops start at 0.
    function automatic logic red_identity(input red_op_e op);
        return (op == RED_AND);
    endfunction

    function automatic logic red_combine(input red_op_e op, input logic a, input logic b);
        logic v;
        case (op)
            RED_AND: v = a & b;
            RED_OR:  v = a | b;
            RED_XOR: v = a ^ b;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unary_reduction_sequencer_chunk_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_reduce
//  Description : N-bit AND/OR/XOR reduction of one chunk; illegal op gives 0.
//  Revision    : 1.0
// ============================================================================
module chunk_reduce
    import unary_reduction_pkg::*;
#(
    parameter string MODEL = "Structural",
    parameter int    N     = 8
) (
    input  logic [N-1:0] chunk,
    input  red_op_e      op,
    output logic         r
);

    if (MODEL == "Behavioral") begin : g_behavioral
        always_comb begin
            r = red_identity(op);
            for (int i = 0; i < N; i++) begin
                r = red_combine(op, r, chunk[i]);
            end
        end
    end else if (MODEL == "DataFlow") begin : g_dataflow
        assign r = (op == RED_AND) ? (&chunk) :
                   (op == RED_OR)  ? (|chunk) :
                   (op == RED_XOR) ? (^chunk) : 1'b0;
    end else begin : g_structural
        // Ripple chains of two-input gates, one stage per bit.
        for (genvar i = 0; i < N; i++) begin : g_bit
            logic w_and;
            logic w_or;
            logic w_xor;
            if (i == 0) begin : g_first
                assign w_and = chunk[0];
                assign w_or  = chunk[0];
                assign w_xor = chunk[0];
            end else begin : g_next
                assign w_and = g_bit[i-1].w_and & chunk[i];
                assign w_or  = g_bit[i-1].w_or  | chunk[i];
                assign w_xor = g_bit[i-1].w_xor ^ chunk[i];
            end
        end

        assign r = (op == RED_AND) ? g_bit[N-1].w_and :
                   (op == RED_OR)  ? g_bit[N-1].w_or  :
                   (op == RED_XOR) ? g_bit[N-1].w_xor : 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/unary_reduction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : unary_reduction_sequencer
//  Description : Streams a W=N*K operand through one N-bit reduction unit,
//                accumulating K partial results behind valid/ready handshakes.
//  Revision    : 1.0
// ============================================================================
module unary_reduction_sequencer
    import unary_reduction_pkg::*;
#(
    parameter string MODEL = "Structural",
    parameter int    N     = 8,
    parameter int    K     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_op,
    input  logic [N*K-1:0] in_a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_c,
    output logic           out_err,
    output logic           busy
);

    localparam int                 c_W        = N * K;
    localparam int                 c_IDXW     = (K > 1) ? $clog2(K) : 1;
    localparam logic [c_IDXW-1:0]  c_LAST_IDX = c_IDXW'(K - 1);

    seq_state_e        r_state;
    logic [c_IDXW-1:0] r_idx;
    logic              r_acc;
    logic [c_W-1:0]    r_a;
    red_op_e           r_base;
    logic              r_inv;
    logic              r_out_c;
    logic              r_out_err;

    logic [N-1:0]      w_chunk;
    logic              w_chunk_r;
    logic              w_acc_next;
    logic              w_illegal;
    red_op_e           w_in_base;

    assign w_chunk    = r_a[int'(r_idx) * N +: N];
    assign w_acc_next = red_combine(r_base, r_acc, w_chunk_r);
    assign w_illegal  = (r_base == RED_ILLEGAL);
    assign w_in_base  = red_op_e'(in_op[1:0]);

    chunk_reduce #(
        .MODEL (MODEL),
        .N     (N)
    ) u_chunk_reduce (
        .chunk (w_chunk),
        .op    (r_base),
        .r     (w_chunk_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_acc     <= 1'b0;
            r_a       <= '0;
            r_base    <= RED_AND;
            r_inv     <= 1'b0;
            r_out_c   <= 1'b0;
            r_out_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_base  <= w_in_base;
                        r_inv   <= in_op[2];
                        r_idx   <= '0;
                        r_acc   <= red_identity(w_in_base);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_idx == c_LAST_IDX) begin
                        // Illegal requests report 0 no matter what the invert bit says.
                        r_out_c   <= w_illegal ? 1'b0 : (w_acc_next ^ r_inv);
                        r_out_err <= w_illegal;
                        r_state   <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_c     = r_out_c;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_unary_reduction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unary_reduction_sequencer
//  Description : Directed self-checking bench for unary_reduction_sequencer.
//  Revision    : 1.0
// ============================================================================
module tb_unary_reduction_sequencer;

    localparam int c_N = 8;
    localparam int c_K = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic        out_c;
    logic        out_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    unary_reduction_sequencer #(
        .MODEL ("Structural"),
        .N     (c_N),
        .K     (c_K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for out_valid after the accept edge; K edges are expected.
    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, c_K);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic exp_c, input logic exp_err);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        step();
        in_valid = 1'b0;
        in_a     = 32'h0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_result(tag);
        check({tag, "_out_c"}, {31'd0, out_c}, {31'd0, exp_c});
        check({tag, "_out_err"}, {31'd0, out_err}, {31'd0, exp_err});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_c", {31'd0, out_c}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_req("and_ones",  3'b000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_req("nand_ones", 3'b100, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_req("or_bit8",   3'b001, 32'h0000_0100, 1'b1, 1'b0);
        run_req("nor_zero",  3'b101, 32'h0000_0000, 1'b1, 1'b0);
        run_req("or_zero",   3'b001, 32'h0000_0000, 1'b0, 1'b0);
        run_req("xor_ends",  3'b010, 32'h8000_0001, 1'b0, 1'b0);
        run_req("xor_7",     3'b010, 32'h0000_0007, 1'b1, 1'b0);
        run_req("xnor_7",    3'b110, 32'h0000_0007, 1'b0, 1'b0);
        run_req("and_one0",  3'b000, 32'hFFFF_7FFF, 1'b0, 1'b0);

        // Backpressure with a competing request held on the input.
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_a     = 32'hFFFF_FFFF;
        step();
        in_op    = 3'b001;
        in_a     = 32'h0000_0000;
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_c", {31'd0, out_c}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
        check("bp_after_hs_busy", {31'd0, busy}, 32'd0);
        check("bp_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, busy}, 32'd1);
        wait_result("bp2");
        check("bp2_out_c", {31'd0, out_c}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset asserted on the second RUN cycle.
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_a     = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_c", {31'd0, out_c}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_result", {31'd0, out_valid}, 32'd0);
        end

        run_req("illegal_011", 3'b011, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_req("illegal_111", 3'b111, 32'h0000_0000, 1'b0, 1'b1);
        run_req("legal_after", 3'b001, 32'h0000_0100, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
